dht11_ctrl: RTL and testbench
=============================

Name: dht11_ctrl

Overview:
- Sequences a complete DHT11 single-wire read: host start pulse, sensor response, 40 data bits, checksum check.
- Contains its own microsecond timebase derived from CLK_IN by a prescale counter, in the style of the freqDiv block.
- Drives the open-drain bus through an output-enable. Publishes humidity and temperature words to downstream display/UART logic.

Parameters:
- FREQ_IN, 25000000, input clock frequency in Hz.
- TICK_HZ, 1000000, timebase tick rate; one tick = 1 us. FREQ_IN/TICK_HZ must be an integer >= 2.
- START_LOW_US, 18000, duration the host holds the bus low.
- TIMEOUT_US, 200, maximum ticks allowed in any sensor-driven phase.
- BIT_THRESH_US, 50, high-phase length at or above which a bit decodes as 1.

Ports:
- CLK_IN  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle request to begin a read; ignored while BUSY=1.
- DATA_IN  input  1  raw bus level; passes through an internal 2-FF synchronizer.
- DATA_OE  output  1  1 = pull the bus low; 0 = release (external pull-up).
- BUSY  output  1  high from the cycle after an accepted START until DONE.
- DONE  output  1  one-cycle pulse at the end of every transaction, good or bad.
- ERR  output  2  0 = ok, 1 = timeout, 2 = checksum; held until the next accepted START.
- HUMIDITY  output  16  {int byte, dec byte}; updated only on an ok transaction.
- TEMPERATURE  output  16  {int byte, dec byte}; updated only on an ok transaction.

Behaviour:
- Reset values: state IDLE, DATA_OE=0, BUSY=0, DONE=0, ERR=0, HUMIDITY=0, TEMPERATURE=0; prescaler, us counter and bit counter at 0; synchronizer at 1.
- Timebase:
  - Prescaler wraps every FREQ_IN/TICK_HZ cycles and emits a 1-cycle tick.
  - The us counter increments on each tick and clears on every state transition. The prescaler also clears on every transition, so phase timing is exact to within one tick.
- Edges: rise/fall are detected on the synchronized DATA_IN, adding 2 cycles of latency.
- State machine:
  - IDLE: START -> START_LOW. ERR cleared, BUSY=1.
  - START_LOW: DATA_OE=1. When us = START_LOW_US -> WAIT_RESP with DATA_OE=0.
  - WAIT_RESP: fall -> RESP_LOW.
  - RESP_LOW: rise -> RESP_HIGH.
  - RESP_HIGH: fall -> BIT_LOW.
  - BIT_LOW: rise -> BIT_HIGH.
  - BIT_HIGH: on fall, shift in (us >= BIT_THRESH_US), MSB first, into a 40-bit register.
    - If the bit count was 39 -> CHECK.
    - Otherwise increment the bit count -> BIT_LOW.
  - CHECK: one cycle.
    - If (b4+b3+b2+b1) mod 256 == b0 -> load HUMIDITY={b4,b3} and TEMPERATURE={b2,b1}, ERR=0.
    - Else ERR=2, outputs unchanged.
    - Then -> FINISH.
  - FINISH: DONE=1 for one cycle, BUSY=0 -> IDLE.
- Timeout: in WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW and BIT_HIGH, us reaching TIMEOUT_US -> ERR=1 -> FINISH. A timeout on the same cycle as the expected edge: the edge wins.
- Last bit: after bit 40 the sensor releases the bus, and that trailing high is not measured.
- START while BUSY=1: ignored, no queueing. START on the FINISH cycle is also ignored.
- Reset mid-transaction: immediate return to reset values; the bus is released asynchronously (DATA_OE=0).
- Widths: the us counter is sized by $clog2 of the largest of START_LOW_US and TIMEOUT_US, plus 1 bit. The checksum sum is computed in 10 bits and its low 8 bits are compared.

Optional Feature:
- DHT11_CHECKSUM_EN defined: CHECK behaves as above.
- Not defined: CHECK loads HUMIDITY/TEMPERATURE unconditionally; ERR never takes value 2.

Test Plan:
- Bench setup: FREQ_IN=2000000, TICK_HZ=1000000, START_LOW_US=100, TIMEOUT_US=200.
- Good frame: START; the sensor model answers 80/80 us, then bytes 0x37,0x00,0x18,0x05,0x54 (0-bit high 27 us, 1-bit high 70 us) -> DATA_OE high exactly 200 cycles, DONE single pulse, ERR=0, HUMIDITY=0x3700, TEMPERATURE=0x1805.
- Bad checksum: same frame with last byte 0x55 -> ERR=2, HUMIDITY/TEMPERATURE keep their previous values. Without DHT11_CHECKSUM_EN -> ERR=0, HUMIDITY=0x3700, TEMPERATURE=0x1805.
- No sensor (bus stays high) -> DONE about 200 us after release, ERR=1, BUSY low afterwards.
- Sensor stops after bit 12 (bus held high) -> ERR=1 at TIMEOUT_US in BIT_HIGH; the next START with a good frame returns ERR=0 and correct data.
- START pulsed mid-transaction, plus RST_N asserted during START_LOW -> extra START ignored (single DONE); on reset DATA_OE=0 immediately and all outputs return to reset values.

Source files
------------

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire read sequencer with built-in microsecond timebase and open-drain bus control.
// Define DHT11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht11_ctrl #(
  parameter int FREQ_IN       = 25000000,
  parameter int TICK_HZ       = 1000000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic        START,
  input  logic        DATA_IN,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  ERR,
  output logic [15:0] HUMIDITY,
  output logic [15:0] TEMPERATURE
);

  localparam int DIV   = FREQ_IN / TICK_HZ;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAXUS = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int UW    = $clog2(MAXUS) + 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [UW-1:0] START_LAST = UW'(START_LOW_US - 1);
  localparam logic [UW-1:0] TO_LAST    = UW'(TIMEOUT_US - 1);
  localparam logic [UW-1:0] THRESH     = UW'(BIT_THRESH_US);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_WAIT_RESP = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_FINISH    = 4'd8
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [UW-1:0]  us_q, us_d;
  logic [5:0]     bitcnt_q, bitcnt_d;
  logic [39:0]    shift_q, shift_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic           oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]     err_q, err_d;
  logic [15:0]    hum_q, hum_d, tem_q, tem_d;
  logic           tick_s, timeout_s, rise_s, fall_s;

  // Sum of the four data bytes, modulo 256, must equal the checksum byte.
  function automatic logic csum_ok(input logic [39:0] frame);
    logic [9:0] sum;
    sum = {2'b00, frame[39:32]} + {2'b00, frame[31:24]}
        + {2'b00, frame[23:16]} + {2'b00, frame[15:8]};
    return (sum[7:0] == frame[7:0]);
  endfunction

  assign tick_s    = (pre_q == PRE_LAST);
  assign timeout_s = tick_s && (us_q == TO_LAST);
  assign rise_s    = sync2_q & ~prev_q;
  assign fall_s    = ~sync2_q & prev_q;

  // Next-state, timebase, shift register and output computation.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    hum_d    = hum_q;
    tem_d    = tem_q;
    sync1_d  = DATA_IN;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    if (tick_s) begin
      pre_d = '0;
      us_d  = us_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
      us_d  = us_q;
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_START_LOW;
          err_d    = ERR_OK;
          busy_d   = 1'b1;
          oe_d     = 1'b1;
          bitcnt_d = 6'd0;
        end else begin
          oe_d = 1'b0;
        end
      end
      S_START_LOW: begin
        // Leave on the tick that brings the count to START_LOW_US.
        if (tick_s && (us_q == START_LAST)) begin
          state_d = S_WAIT_RESP;
          oe_d    = 1'b0;
        end else begin
          oe_d = 1'b1;
        end
      end
      S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
        if ((state_q == S_WAIT_RESP) && fall_s) begin
          state_d = S_RESP_LOW;
        end else if ((state_q == S_RESP_LOW) && rise_s) begin
          state_d = S_RESP_HIGH;
        end else if ((state_q == S_RESP_HIGH) && fall_s) begin
          state_d = S_BIT_LOW;
        end else if ((state_q == S_BIT_LOW) && rise_s) begin
          state_d = S_BIT_HIGH;
        end else if ((state_q == S_BIT_HIGH) && fall_s) begin
          shift_d = {shift_q[38:0], (us_q >= THRESH)};
          if (bitcnt_q == 6'd39) begin
            state_d = S_CHECK;
          end else begin
            bitcnt_d = bitcnt_q + 6'd1;
            state_d  = S_BIT_LOW;
          end
        end else if (timeout_s) begin
          state_d = S_FINISH;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
`ifdef DHT11_CHECKSUM_EN
        if (csum_ok(shift_q)) begin
          hum_d = shift_q[39:24];
          tem_d = shift_q[23:8];
          err_d = ERR_OK;
        end else begin
          err_d = ERR_CSUM;
        end
`else
        hum_d = shift_q[39:24];
        tem_d = shift_q[23:8];
        err_d = ERR_OK;
`endif
        state_d = S_FINISH;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end else begin
      pre_d = pre_d;
    end
  end

  // State and datapath registers; reset releases the bus immediately.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      us_q     <= '0;
      bitcnt_q <= 6'd0;
      shift_q  <= 40'd0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
      hum_q    <= 16'd0;
      tem_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      us_q     <= us_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hum_q    <= hum_d;
      tem_q    <= tem_d;
    end
  end

  assign DATA_OE     = oe_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign HUMIDITY    = hum_q;
  assign TEMPERATURE = tem_q;

endmodule

// File: tb/tb_dht11_ctrl.sv
// Randomized bench for dht11_ctrl: a DHT11 sensor model on the bus and a frame-level expectation model.
module tb_dht11_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sens = 1'b1;
  logic        data_in;
  logic        oe, busy, done;
  logic [1:0]  err;
  logic [15:0] hum, tem;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int oe_cnt = 0;
  int oe_fall_cyc = 0;
  int done_cyc = 0;
  logic oe_prev = 1'b0;

  logic [15:0] exp_hum = 16'd0;
  logic [15:0] exp_tem = 16'd0;

  always #5 clk = ~clk;

  // Open-drain bus: host pull-down wins over the sensor.
  assign data_in = oe ? 1'b0 : sens;

  dht11_ctrl #(
    .FREQ_IN(2000000), .TICK_HZ(1000000), .START_LOW_US(100), .TIMEOUT_US(200), .BIT_THRESH_US(50)
  ) dut (
    .CLK_IN(clk), .RST_N(rst_n), .START(start), .DATA_IN(data_in),
    .DATA_OE(oe), .BUSY(busy), .DONE(done), .ERR(err),
    .HUMIDITY(hum), .TEMPERATURE(tem)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (oe === 1'b1) oe_cnt = oe_cnt + 1;
    if (oe_prev === 1'b1 && oe === 1'b0) oe_fall_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    oe_prev = oe;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  function automatic logic [39:0] mk_frame(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3, input bit good);
    int s;
    logic [7:0] ck;
    s  = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
    ck = good ? 8'(s) : 8'((s + 1 + int'($urandom_range(0, 254))) % 256);
    return {b0, b1, b2, b3, ck};
  endfunction

  // One host transaction; nbits < 40 means the sensor goes silent (bus high) after that many bits.
  task automatic run_frame(input string tag, input logic [39:0] frame, input int nbits,
                           input bit respond, input bit extra_start);
    int base, oe_base, lim, low, s;
    bit good;
    logic [1:0] exp_err;
    base    = done_cnt;
    oe_base = oe_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_busy_up"}, {31'd0, busy}, 32'd1);
    check_val({tag, "_err_clr"}, {30'd0, err}, 32'd0);
    lim = 0;
    while (oe !== 1'b0 && lim < 1000) begin
      @(negedge clk);
      lim = lim + 1;
    end
    check_val({tag, "_release"}, {31'd0, (oe === 1'b0)}, 32'd1);
    check_val({tag, "_oe_len"}, oe_cnt - oe_base, 32'd200);

    if (respond) begin
      wait_us($urandom_range(20, 40));
      sens = 1'b0;
      wait_us($urandom_range(70, 90));
      sens = 1'b1;
      wait_us($urandom_range(70, 90));
      for (int i = 0; i < nbits; i++) begin
        sens = 1'b0;
        low  = $urandom_range(30, 55);
        if (extra_start && i == 5) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (2 * low - 1) @(negedge clk);
        end else begin
          wait_us(low);
        end
        sens = 1'b1;
        wait_us(frame[39 - i] ? $urandom_range(62, 75) : $urandom_range(20, 30));
      end
      if (nbits == 40) begin
        sens = 1'b0;
        wait_us(50);
        sens = 1'b1;
      end
    end

    lim = 0;
    while (done_cnt == base && lim < 2000) begin
      @(negedge clk);
      lim = lim + 1;
    end
    check_val({tag, "_done_seen"}, {31'd0, (done_cnt != base)}, 32'd1);
    if (!respond) begin
      check_val({tag, "_timeout_lat"},
                {31'd0, ((done_cyc - oe_fall_cyc) >= 398 && (done_cyc - oe_fall_cyc) <= 402)}, 32'd1);
    end
    repeat (5) @(negedge clk);

    if (!respond || nbits < 40) begin
      exp_err = 2'd1;
    end else begin
      s = (int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8])) % 256;
`ifdef DHT11_CHECKSUM_EN
      good = (s == int'(frame[7:0]));
`else
      good = 1'b1;
`endif
      if (good) begin
        exp_err = 2'd0;
        exp_hum = frame[39:24];
        exp_tem = frame[23:8];
      end else begin
        exp_err = 2'd2;
      end
    end
    check_val({tag, "_done_once"}, done_cnt - base, 32'd1);
    check_val({tag, "_busy_down"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_val({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
    check_val({tag, "_hum"}, {16'd0, hum}, {16'd0, exp_hum});
    check_val({tag, "_tem"}, {16'd0, tem}, {16'd0, exp_tem});
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_oe"}, {31'd0, oe}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_err"}, {30'd0, err}, 32'd0);
    check_val({tag, "_hum"}, {16'd0, hum}, 32'd0);
    check_val({tag, "_tem"}, {16'd0, tem}, 32'd0);
  endtask

  initial begin
    logic [39:0] f;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame("good", 40'h3700180554, 40, 1'b1, 1'b0);
    run_frame("badck", 40'h3700180555, 40, 1'b1, 1'b0);
    run_frame("nosens", 40'h0, 0, 1'b0, 1'b0);
    f = mk_frame(8'h2a, 8'h00, 8'h15, 8'h03, 1'b1);
    run_frame("stop12", f, 12, 1'b1, 1'b0);
    f = mk_frame(8'h41, 8'h01, 8'h1a, 8'h09, 1'b1);
    run_frame("good_xstart", f, 40, 1'b1, 1'b1);

    for (int k = 0; k < 4; k++) begin
      f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      run_frame($sformatf("rnd%0d", k), f, 40, 1'b1, $urandom_range(0, 1) == 1);
    end

    run_frame("pre_rst", 40'h3700180554, 40, 1'b1, 1'b0);

    // Reset while the host is holding the bus low.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_val("midrst_oe_before", {31'd0, oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_hum = 16'd0;
    exp_tem = 16'd0;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    f = mk_frame(8'h33, 8'h00, 8'h17, 8'h02, 1'b1);
    run_frame("after_rst", f, 40, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
